// File: rtl/score_keeper.sv
// Pong-style score keeper: counts ball/paddle contacts in BCD, tracks the high score
// and draws both as 3-digit seven-segment overlays with a one-cycle registered output.
module score_keeper #(
    parameter int SCORE_X = 16,
    parameter int HIGH_X  = 1160,
    parameter int FIELD_Y = 16,
    parameter int SEG_LEN = 16,
    parameter int SEG_W   = 4
) (
    input  logic              pixel_clk,
    input  logic              rst,
    input  logic              fsync,
    input  logic              game_over,
    input  logic              active_obj,
    input  logic              active_paddle,
    input  logic signed [11:0] hpos,
    input  logic signed [11:0] vpos,
    output logic [2:0][7:0]   pixel_score,
    output logic              active_score,
    output logic [11:0]       score_bcd,
    output logic [11:0]       high_bcd
);

    localparam int DW    = SEG_LEN + 2 * SEG_W;
    localparam int DH    = 2 * SEG_LEN + 3 * SEG_W;
    localparam int PITCH = DW + SEG_W;

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] CONTACT = 1'b1;

    logic [0:0]      state_q, state_d;
    logic            hit_q, hit_d;
    logic            synced_q, synced_d;
    logic            go_q;
    logic [11:0]     score_q, score_d;
    logic [11:0]     high_q, high_d;
    logic [11:0]     snap_score_q, snap_score_d;
    logic [11:0]     snap_high_q, snap_high_d;
    logic [2:0][7:0] pix_q, pix_d;
    logic            act_q, act_d;

    logic            overlap, go_rise, go_fall;
    logic            score_on, high_on;
    int              hx, vy;

    // Saturating 3-digit BCD increment.
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v != 12'h999) begin
            if (v[3:0] != 4'd9) begin
                r[3:0] = v[3:0] + 4'd1;
            end else begin
                r[3:0] = '0;
                if (v[7:4] != 4'd9) begin
                    r[7:4] = v[7:4] + 4'd1;
                end else begin
                    r[7:4]  = '0;
                    r[11:8] = v[11:8] + 4'd1;
                end
            end
        end
        return r;
    endfunction

    // Segment mask {a,b,c,d,e,f,g}; non-decimal codes stay dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] m;
        case (code)
            4'd0:    m = 7'b1111110;
            4'd1:    m = 7'b0110000;
            4'd2:    m = 7'b1101101;
            4'd3:    m = 7'b1111001;
            4'd4:    m = 7'b0110011;
            4'd5:    m = 7'b1011011;
            4'd6:    m = 7'b1011111;
            4'd7:    m = 7'b1110000;
            4'd8:    m = 7'b1111111;
            4'd9:    m = 7'b1111011;
            default: m = 7'b0000000;
        endcase
        return m;
    endfunction

    function automatic logic seg_lit(input logic [6:0] m, input int x, input int y);
        logic upper, lower, left, right;
        upper = (y < SEG_LEN + 2 * SEG_W);
        lower = (y >= SEG_LEN + SEG_W);
        left  = (x < SEG_W);
        right = (x >= DW - SEG_W);
        return (m[6] && (y < SEG_W))
            || (m[0] && (y >= SEG_LEN + SEG_W) && (y < SEG_LEN + 2 * SEG_W))
            || (m[3] && (y >= DH - SEG_W))
            || (m[5] && right && upper)
            || (m[1] && left && upper)
            || (m[4] && right && lower)
            || (m[2] && left && lower);
    endfunction

    // dx/dy are relative to the field's top-left corner.
    function automatic logic field_lit(input logic [11:0] bcd, input int dx, input int dy);
        logic       lit;
        logic [3:0] code;
        int         x0;
        lit = 1'b0;
        if (dy >= 0 && dy < DH) begin
            for (int unsigned i = 0; i < 3; i++) begin
                x0 = int'(i) * PITCH;
                case (i)
                    0:       code = bcd[11:8];
                    1:       code = bcd[7:4];
                    default: code = bcd[3:0];
                endcase
                if (dx >= x0 && dx < x0 + DW)
                    lit = lit | seg_lit(seg_decode(code), dx - x0, dy);
            end
        end
        return lit;
    endfunction

    assign overlap = active_obj & active_paddle;
    assign go_rise = game_over & ~go_q;
    assign go_fall = ~game_over & go_q;

    always_comb begin
        state_d      = state_q;
        score_d      = score_q;
        high_d       = high_q;
        synced_d     = synced_q | fsync;
        snap_score_d = fsync ? score_q : snap_score_q;
        snap_high_d  = fsync ? high_q : snap_high_q;

        // Hits before the first post-reset fsync belong to a partial frame and are dropped.
        if (game_over)
            hit_d = 1'b0;
        else if (fsync)
            hit_d = overlap;
        else
            hit_d = hit_q | (overlap & synced_q);

        if (game_over) begin
            state_d = IDLE;
            if (go_rise && (score_q > high_q))
                high_d = score_q;
        end else begin
            if (fsync) begin
                if (state_q == IDLE && hit_q) begin
                    state_d = CONTACT;
                    score_d = bcd_inc(score_q);
                end else if (state_q == CONTACT && !hit_q) begin
                    state_d = IDLE;
                end
            end
            if (go_fall)
                score_d = '0;
        end
    end

    always_comb begin
        hx       = int'(hpos);
        vy       = int'(vpos);
        score_on = 1'b0;
        high_on  = 1'b0;
        if (hx >= 0 && vy >= 0) begin
            score_on = field_lit(snap_score_q, hx - SCORE_X, vy - FIELD_Y);
            high_on  = field_lit(snap_high_q, hx - HIGH_X, vy - FIELD_Y);
        end
        act_d = score_on | high_on;
        if (score_on)
            pix_d = {8'hFF, 8'hFF, 8'hFF};
        else if (high_on)
            pix_d = {8'hFF, 8'hFF, 8'h00};
        else
            pix_d = '0;
    end

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            hit_q        <= 1'b0;
            synced_q     <= 1'b0;
            go_q         <= 1'b0;
            score_q      <= '0;
            high_q       <= '0;
            snap_score_q <= '0;
            snap_high_q  <= '0;
            pix_q        <= '0;
            act_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            hit_q        <= hit_d;
            synced_q     <= synced_d;
            go_q         <= game_over;
            score_q      <= score_d;
            high_q       <= high_d;
            snap_score_q <= snap_score_d;
            snap_high_q  <= snap_high_d;
            pix_q        <= pix_d;
            act_q        <= act_d;
        end
    end

    assign pixel_score  = pix_q;
    assign active_score = act_q;
    assign score_bcd    = score_q;
    assign high_bcd     = high_q;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: directed scenarios with literal expectations plus random
// frames, all compared every cycle against a decimal-integer model of the scoreboard.
module tb_score_keeper;

    localparam int SCORE_X = 16;
    localparam int HIGH_X  = 1160;
    localparam int FIELD_Y = 16;
    localparam int SEG_LEN = 16;
    localparam int SEG_W   = 4;
    localparam int DW      = SEG_LEN + 2 * SEG_W;
    localparam int DH      = 2 * SEG_LEN + 3 * SEG_W;
    localparam int P       = DW + SEG_W;

    logic              pixel_clk = 1'b0;
    logic              rst = 1'b1;
    logic              fsync = 1'b0;
    logic              game_over = 1'b0;
    logic              active_obj = 1'b0;
    logic              active_paddle = 1'b0;
    logic signed [11:0] hpos = -12'sd1;
    logic signed [11:0] vpos = -12'sd1;
    logic [2:0][7:0]   pixel_score;
    logic              active_score;
    logic [11:0]       score_bcd;
    logic [11:0]       high_bcd;

    score_keeper #(
        .SCORE_X(SCORE_X), .HIGH_X(HIGH_X), .FIELD_Y(FIELD_Y),
        .SEG_LEN(SEG_LEN), .SEG_W(SEG_W)
    ) dut (
        .pixel_clk    (pixel_clk),
        .rst          (rst),
        .fsync        (fsync),
        .game_over    (game_over),
        .active_obj   (active_obj),
        .active_paddle(active_paddle),
        .hpos         (hpos),
        .vpos         (vpos),
        .pixel_score  (pixel_score),
        .active_score (active_score),
        .score_bcd    (score_bcd),
        .high_bcd     (high_bcd)
    );

    always #5 pixel_clk = ~pixel_clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    string SEGS[10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                        "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

    function automatic bit seg_hit(byte s, int c, int r);
        case (s)
            "a": return r < SEG_W;
            "g": return r >= SEG_LEN + SEG_W && r < SEG_LEN + 2 * SEG_W;
            "d": return r >= DH - SEG_W;
            "f": return c < SEG_W && r < SEG_LEN + 2 * SEG_W;
            "b": return c >= DW - SEG_W && r < SEG_LEN + 2 * SEG_W;
            "e": return c < SEG_W && r >= SEG_LEN + SEG_W;
            "c": return c >= DW - SEG_W && r >= SEG_LEN + SEG_W;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit field_on(int val, int h, int v, int x0);
        int dx, dy, k, c, dig;
        string s;
        if (h < 0 || v < 0) return 1'b0;
        dx = h - x0;
        dy = v - FIELD_Y;
        if (dx < 0 || dy < 0 || dy >= DH || dx >= 3 * P) return 1'b0;
        k = dx / P;
        c = dx % P;
        if (c >= DW) return 1'b0;
        dig = (k == 0) ? val / 100 : (k == 1) ? (val / 10) % 10 : val % 10;
        s = SEGS[dig];
        for (int i = 0; i < s.len(); i++)
            if (seg_hit(s[i], c, dy)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [11:0] to_bcd(int n);
        return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    int          m_score = 0, m_high = 0, m_snap_s = 0, m_snap_h = 0;
    bit          m_hit = 0, m_contact = 0, m_synced = 0, m_go = 0, m_act = 0;
    logic [23:0] m_pix = '0;

    always @(posedge pixel_clk or posedge rst) begin
        bit ov, sl, hl;
        if (rst) begin
            m_score = 0; m_high = 0; m_snap_s = 0; m_snap_h = 0;
            m_hit = 0; m_contact = 0; m_synced = 0; m_go = 0;
            m_act = 0; m_pix = '0;
        end else begin
            ov = active_obj && active_paddle;
            sl = field_on(m_snap_s, int'(hpos), int'(vpos), SCORE_X);
            hl = field_on(m_snap_h, int'(hpos), int'(vpos), HIGH_X);
            m_act = sl || hl;
            m_pix = sl ? 24'hFFFFFF : hl ? 24'hFFFF00 : 24'h000000;
            if (fsync) begin
                m_snap_s = m_score;
                m_snap_h = m_high;
            end
            if (game_over) begin
                if (!m_go && m_score > m_high) m_high = m_score;
                m_contact = 0;
            end else begin
                if (fsync) begin
                    if (m_hit && !m_contact) begin
                        m_contact = 1;
                        if (m_score < 999) m_score = m_score + 1;
                    end else if (!m_hit) begin
                        m_contact = 0;
                    end
                end
                if (m_go) m_score = 0;
            end
            m_hit    = game_over ? 1'b0 : fsync ? ov : (m_hit || (ov && m_synced));
            m_synced = m_synced || fsync;
            m_go     = game_over;
        end
    end

    always @(negedge pixel_clk) begin
        if (chk_en) begin
            check("active_score", 24'(active_score), 24'(m_act));
            check("pixel_score", 24'(pixel_score), m_pix);
            check("score_bcd", 24'(score_bcd), 24'(to_bcd(m_score)));
            check("high_bcd", 24'(high_bcd), 24'(to_bcd(m_high)));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit f, input bit ov);
        fsync = f;
        active_obj = ov;
        active_paddle = ov;
        @(negedge pixel_clk);
    endtask

    task automatic contact();
        cyc(0, 1); cyc(1, 0); cyc(0, 0); cyc(1, 0);
    endtask

    task automatic do_reset();
        fsync = 0; active_obj = 0; active_paddle = 0; game_over = 0;
        #1 rst = 1'b1;
        @(negedge pixel_clk);
        #1 rst = 1'b0;
        @(negedge pixel_clk);
        cyc(1, 0);
    endtask

    initial begin
        bit ball_on;
        int pick;
        #1 chk_en = 1'b1;
        check("rst_score", 24'(score_bcd), 24'h0);
        check("rst_high", 24'(high_bcd), 24'h0);
        check("rst_active", 24'(active_score), 24'h0);
        check("rst_pixel", 24'(pixel_score), 24'h0);
        @(negedge pixel_clk);
        @(negedge pixel_clk);
        #1 rst = 1'b0;
        @(negedge pixel_clk);

        // Overlap in the partial frame after reset must not count.
        cyc(0, 1); cyc(0, 0); cyc(1, 0);
        check("partial_frame", 24'(score_bcd), 24'h000);
        cyc(0, 1); cyc(0, 0); cyc(1, 0);
        check("fsync2", 24'(score_bcd), 24'h001);
        cyc(0, 0); cyc(1, 0);
        check("fsync3", 24'(score_bcd), 24'h001);
        cyc(0, 1); cyc(1, 0);
        check("fsync4", 24'(score_bcd), 24'h002);
        cyc(0, 0); cyc(1, 0);

        repeat (5) begin cyc(0, 1); cyc(1, 0); end
        check("five_frames", 24'(score_bcd), 24'h003);
        cyc(0, 0); cyc(1, 0);

        repeat (96) contact();
        check("preload_099", 24'(score_bcd), 24'h099);
        contact();
        check("carry_100", 24'(score_bcd), 24'h100);
        repeat (899) contact();
        check("reach_999", 24'(score_bcd), 24'h999);
        contact();
        check("saturate_999", 24'(score_bcd), 24'h999);

        // Display of a zero snapshot.
        do_reset();
        for (int x = 0; x < DW; x++) begin
            hpos = 12'(SCORE_X + x); vpos = 12'(FIELD_Y);
            @(negedge pixel_clk);
            check("top_row_act", 24'(active_score), 24'h1);
            check("top_row_pix", 24'(pixel_score), 24'hFFFFFF);
        end
        hpos = -12'sd1;
        #1 check("registered_out", 24'(active_score), 24'h1);
        for (int x = 0; x < DW; x++) begin
            bit e;
            e = (x < SEG_W) || (x >= DW - SEG_W);
            hpos = 12'(SCORE_X + x); vpos = 12'(FIELD_Y + SEG_LEN + SEG_W);
            @(negedge pixel_clk);
            check("g_band_act", 24'(active_score), 24'(e));
            check("g_band_pix", 24'(pixel_score), e ? 24'hFFFFFF : 24'h000000);
        end
        hpos = 12'(HIGH_X); vpos = 12'(FIELD_Y);
        @(negedge pixel_clk);
        check("high_colour", 24'(pixel_score), 24'hFFFF00);
        hpos = 12'(SCORE_X + DW);
        @(negedge pixel_clk);
        check("digit_gap", 24'(active_score), 24'h0);
        hpos = -12'sd2;
        @(negedge pixel_clk);
        check("neg_hpos", 24'(active_score), 24'h0);
        hpos = -12'sd1; vpos = -12'sd1;

        // Game-over high score transfer.
        do_reset();
        repeat (3) contact();
        game_over = 1; cyc(0, 0);
        check("high_003", 24'(high_bcd), 24'h003);
        game_over = 0; cyc(0, 0);
        check("clear_after_go", 24'(score_bcd), 24'h000);
        repeat (7) contact();
        check("score_007", 24'(score_bcd), 24'h007);
        game_over = 1; cyc(0, 0);
        check("high_007", 24'(high_bcd), 24'h007);
        cyc(1, 1); cyc(0, 1); cyc(1, 0);
        check("held_during_go", 24'(score_bcd), 24'h007);
        game_over = 0; cyc(0, 0);
        check("score_000", 24'(score_bcd), 24'h000);
        check("high_kept", 24'(high_bcd), 24'h007);
        cyc(0, 1);
        game_over = 1; cyc(1, 0);
        check("go_beats_fsync", 24'(score_bcd), 24'h000);
        game_over = 0; cyc(0, 0);

        // Asynchronous reset while in CONTACT.
        do_reset();
        repeat (3) contact();
        cyc(0, 1); cyc(1, 0);
        hpos = 12'(SCORE_X); vpos = 12'(FIELD_Y);
        cyc(0, 0);
        check("score_004", 24'(score_bcd), 24'h004);
        check("lit_before_rst", 24'(active_score), 24'h1);
        #2 rst = 1'b1;
        #1;
        check("async_score", 24'(score_bcd), 24'h0);
        check("async_high", 24'(high_bcd), 24'h0);
        check("async_active", 24'(active_score), 24'h0);
        check("async_pixel", 24'(pixel_score), 24'h0);
        @(negedge pixel_clk);
        #1 rst = 1'b0;
        hpos = -12'sd1;
        @(negedge pixel_clk);
        cyc(1, 0); cyc(0, 1); cyc(1, 0);
        check("idle_after_rst", 24'(score_bcd), 24'h001);

        // Random frames.
        ball_on = 0;
        repeat (4000) begin
            fsync = ($urandom_range(15) == 0);
            if (fsync) ball_on = $urandom_range(1) == 1;
            active_obj    = ball_on ? ($urandom_range(1) == 1) : ($urandom_range(7) == 0);
            active_paddle = ($urandom_range(1) == 1);
            if ($urandom_range(299) == 0) game_over = ~game_over;
            pick = int'($urandom_range(2));
            if (pick == 0)      hpos = 12'(SCORE_X - 4 + int'($urandom_range(3 * P + 8)));
            else if (pick == 1) hpos = 12'(HIGH_X - 4 + int'($urandom_range(3 * P + 8)));
            else                hpos = 12'(-int'($urandom_range(50)));
            vpos = 12'(FIELD_Y - 20 + int'($urandom_range(DH + 28)));
            #1 rst = ($urandom_range(999) == 0);
            @(negedge pixel_clk);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter SCORE_X, default 16: left column of the 3-digit current-score field.
REQ-002 Parameter HIGH_X, default 1160: left column of the 3-digit high-score field.
REQ-003 Parameter FIELD_Y, default 16: top row of both fields.
REQ-004 Parameter SEG_LEN, default 16: segment length in pixels; parameter SEG_W, default 4: segment thickness in pixels.
REQ-005 pixel_clk  in  1  pixel clock, sole clock.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 fsync  in  1  one-cycle frame-start pulse.
REQ-008 game_over  in  1  level, high while game is over.
REQ-009 active_obj  in  1  ball pixel active at current hpos/vpos.
REQ-010 active_paddle  in  1  paddle pixel active at current hpos/vpos.
REQ-011 hpos  in  12 signed  current pixel column.
REQ-012 vpos  in  12 signed  current pixel row.
REQ-013 pixel_score  out  3x8  RGB overlay; [2] red, [1] green, [0] blue.
REQ-014 active_score  out  1  overlay pixel lit.
REQ-015 score_bcd  out  12  current score, 3 BCD digits, [11:8] hundreds.
REQ-016 high_bcd  out  12  high score, same encoding.

Function
REQ-017 hit_seen SHALL set on any cycle with active_obj & active_paddle and clear on fsync; an overlap in the fsync cycle SHALL set hit_seen for the new frame.
REQ-018 Contact FSM states IDLE and CONTACT, evaluated only on fsync: IDLE & hit_seen -> CONTACT with score +1; CONTACT & !hit_seen -> IDLE; all other cases hold.
REQ-019 A ball overlapping the paddle over N consecutive frames SHALL add exactly 1.
REQ-020 Score increment SHALL be BCD with digit carry (009->010, 099->100) and SHALL saturate at 999.
REQ-021 Registered game_over rising edge: if score > high then high <= score in the same cycle; FSM forced to IDLE.
REQ-022 While game_over high: hit_seen ignored, no increments, score held.
REQ-023 Registered game_over falling edge: score <= 000; high retained.
REQ-024 fsync increment coinciding with game_over rising edge: game_over wins, no increment, high compared against pre-increment score.
REQ-025 Display snapshot of score and high SHALL be latched on fsync only; digits never change mid-frame.
REQ-026 Digit cell: width W = SEG_LEN+2*SEG_W, height H = 2*SEG_LEN+3*SEG_W, digit pitch W+SEG_W, leading zeros shown.
REQ-027 Segments: a rows [0,SEG_W); g rows [SEG_LEN+SEG_W, SEG_LEN+2*SEG_W); d rows [H-SEG_W,H), all full width; f/b cols [0,SEG_W)/[W-SEG_W,W) rows [0,SEG_LEN+2*SEG_W); e/c same cols rows [SEG_LEN+SEG_W,H).
REQ-028 Standard 7-segment decode for 0-9; BCD codes 10-15 SHALL light no segments.
REQ-029 Score field colour R=FF G=FF B=FF; high field R=FF G=FF B=00; unlit pixel_score=0,0,0 and active_score=0.
REQ-030 Negative hpos or vpos SHALL never light a pixel.
REQ-031 pixel_score and active_score SHALL be registered, valid exactly 1 pixel_clk after the hpos/vpos they correspond to.
REQ-032 score_bcd and high_bcd SHALL reflect internal registers directly, not the display snapshot.

Reset
REQ-033 rst asserted SHALL immediately clear score_bcd, high_bcd, snapshots, hit_seen, registered game_over, pixel_score, active_score to 0 and FSM to IDLE.
REQ-034 rst asserted mid-frame SHALL discard any pending hit; first increment possible at second fsync after release.

Verification
REQ-035 Overlap 1 cycle in frame 1, none in frame 2, overlap in frame 3 -> score_bcd 001 after fsync 2, 002 after fsync 4.
REQ-036 Overlap in 5 consecutive frames -> score_bcd 001 only.
REQ-037 Preload 099 via hits, one more contact -> 100; from 999 further contact -> 999.
REQ-038 Score 007, high 003, raise game_over -> high_bcd 007 next cycle; drop game_over -> score_bcd 000, high_bcd 007.
REQ-039 Snapshot score 0, scan hpos=SCORE_X..SCORE_X+W-1 at vpos=FIELD_Y -> active_score 1 for all, one cycle late, pixel FF/FF/FF; at row FIELD_Y+SEG_LEN+SEG_W (g band) inside digit -> 0 except b/c/e/f columns.
REQ-040 Assert rst during CONTACT with score 004 -> all outputs 0 asynchronously, FSM IDLE.
